xadc_drp_responder: RTL and testbench

//   DRP responder emulating the XADC register port, so DRP initiators (channel-select/readout logic)
//   can run against a known model in simulation and in hardware bring-up without the XADC primitive.

---
 rtl/xadc_drp_responder.sv | 134 +++++++++++++
 tb/tb_xadc_drp_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_responder.sv
// rtl/xadc_drp_responder.sv - DRP responder emulating the XADC register port
// Status bank 0x00-0x3F is fed by the sample port; config bank 0x40-0x7F is DRP read/write.
module xadc_drp_responder #(
   parameter int          RD_LATENCY = 4,
   parameter logic [15:0] CFG_RESET  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        den_in,
   input  logic        dwe_in,
   input  logic [6:0]  daddr_in,
   input  logic [15:0] di_in,
   output logic [15:0] do_out,
   output logic        drdy_out,
   output logic        busy_out,
   input  logic        smp_valid,
   input  logic [4:0]  smp_ch,
   input  logic [15:0] smp_data,
   output logic        eoc_out,
   output logic [4:0]  channel_out,
   output logic        ovl_err
);

   localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] rdata_q, rdata_d;
   logic        accept;
   logic        ovl_set;
   logic [15:0] rd_val;

   logic [15:0] stat_q [64];
   logic [15:0] cfg_q  [64];
   logic        eoc_q;
   logic [4:0]  chan_q;
   logic        ovl_q;

   // Snapshot is taken from the arrays before this cycle's edge updates them.
   assign rd_val = daddr_in[6] ? cfg_q[daddr_in[5:0]] : stat_q[daddr_in[5:0]];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      accept  = 1'b0;
      ovl_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (den_in) begin
               accept  = 1'b1;
               cnt_d   = CNT_INIT;
               rdata_d = dwe_in ? 16'h0000 : rd_val;
               state_d = (RD_LATENCY == 1) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            ovl_set = den_in;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ovl_set = den_in;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 16'h0000;
         ovl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         ovl_q   <= ovl_q | ovl_set;
      end
   end

   // Writes below 0x40 still complete on the bus but never reach storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) begin
            cfg_q[i] <= CFG_RESET;
         end
      end else if (accept && dwe_in && daddr_in[6]) begin
         cfg_q[daddr_in[5:0]] <= di_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) begin
            stat_q[i] <= 16'h0000;
         end
      end else if (smp_valid) begin
         stat_q[{1'b0, smp_ch}] <= smp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         eoc_q  <= 1'b0;
         chan_q <= 5'd0;
      end else begin
         eoc_q <= smp_valid;
         if (smp_valid) begin
            chan_q <= smp_ch;
         end
      end
   end

   assign drdy_out    = (state_q == ST_DONE);
   assign busy_out    = (state_q != ST_IDLE);
   assign do_out      = drdy_out ? rdata_q : 16'h0000;
   assign eoc_out     = eoc_q;
   assign channel_out = chan_q;
   assign ovl_err     = ovl_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb/tb_xadc_drp_responder.sv - randomized bench for xadc_drp_responder against a register-map model
// Two instances: default latency 4 and a latency-1 build sharing all inputs except den.
module tb_xadc_drp_responder;

   localparam logic [15:0] CFG0 = 16'hC3A5;
   localparam logic [15:0] CFG1 = 16'h0F0F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, den0, den1, dwe, smp_valid, sel;
   logic [6:0]  daddr;
   logic [15:0] di, smp_data;
   logic [4:0]  smp_ch;

   logic [15:0] do0, do1;
   logic        drdy0, drdy1, busy0, busy1, eoc0, eoc1, ovl0, ovl1;
   logic [4:0]  ch0, ch1;

   xadc_drp_responder #(.RD_LATENCY(4), .CFG_RESET(CFG0)) u_dut0 (
      .clk(clk), .rst(rst), .den_in(den0), .dwe_in(dwe), .daddr_in(daddr), .di_in(di),
      .do_out(do0), .drdy_out(drdy0), .busy_out(busy0), .smp_valid(smp_valid),
      .smp_ch(smp_ch), .smp_data(smp_data), .eoc_out(eoc0), .channel_out(ch0), .ovl_err(ovl0)
   );

   xadc_drp_responder #(.RD_LATENCY(1), .CFG_RESET(CFG1)) u_dut1 (
      .clk(clk), .rst(rst), .den_in(den1), .dwe_in(dwe), .daddr_in(daddr), .di_in(di),
      .do_out(do1), .drdy_out(drdy1), .busy_out(busy1), .smp_valid(smp_valid),
      .smp_ch(smp_ch), .smp_data(smp_data), .eoc_out(eoc1), .channel_out(ch1), .ovl_err(ovl1)
   );

   logic [15:0] o_do;
   logic        o_drdy, o_busy;
   assign o_do   = sel ? do1 : do0;
   assign o_drdy = sel ? drdy1 : drdy0;
   assign o_busy = sel ? busy1 : busy0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] stat_m [64];
   logic [15:0] cfg_m  [2][64];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) begin
         stat_m[i]    = 16'h0000;
         cfg_m[0][i]  = CFG0;
         cfg_m[1][i]  = CFG1;
      end
   endfunction

   function automatic logic [15:0] model_read(input bit s, input logic [6:0] a);
      return a[6] ? cfg_m[s][a[5:0]] : stat_m[a[5:0]];
   endfunction

   // One DRP transaction, optionally with a sample in the same cycle as den.
   task automatic txn(input bit s, input bit we, input logic [6:0] a, input logic [15:0] d,
                      input bit with_smp, input logic [4:0] sch, input logic [15:0] sdat);
      int lat;
      logic [15:0] exp;
      lat = s ? 1 : 4;
      @(posedge clk); #1;
      sel = s;
      chk("idle_before_den", o_busy, 1'b0);
      if (s) den1 = 1'b1; else den0 = 1'b1;
      dwe = we; daddr = a; di = d;
      smp_valid = with_smp; smp_ch = sch; smp_data = sdat;
      exp = we ? 16'h0000 : model_read(s, a);
      if (we && a[6]) cfg_m[s][a[5:0]] = d;
      if (with_smp) stat_m[{1'b0, sch}] = sdat;
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         den0 = 1'b0; den1 = 1'b0; dwe = 1'b0; smp_valid = 1'b0;
         if (k == 1 && with_smp) begin
            chk("txn_eoc", eoc0, 1'b1);
            chk("txn_chan", ch0, sch);
         end
         chk("txn_busy", o_busy, 1'b1);
         chk("txn_drdy", o_drdy, (k == lat));
         chk("txn_do", o_do, (k == lat) ? exp : 16'h0000);
      end
   endtask

   task automatic smp(input logic [4:0] sch, input logic [15:0] sdat);
      @(posedge clk); #1;
      smp_valid = 1'b1; smp_ch = sch; smp_data = sdat;
      stat_m[{1'b0, sch}] = sdat;
      @(posedge clk); #1;
      smp_valid = 1'b0;
      chk("smp_eoc_hi", eoc0, 1'b1);
      chk("smp_chan", ch0, sch);
      @(posedge clk); #1;
      chk("smp_eoc_lo", eoc0, 1'b0);
      chk("smp_chan_hold", ch0, sch);
   endtask

   initial begin
      int ndr, first;
      logic [15:0] exp;
      rst = 1'b1; den0 = 1'b0; den1 = 1'b0; dwe = 1'b0; daddr = '0; di = '0;
      smp_valid = 1'b0; smp_ch = '0; smp_data = '0; sel = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_do0", do0, 16'h0);  chk("rst_drdy0", drdy0, 1'b0); chk("rst_busy0", busy0, 1'b0);
      chk("rst_eoc0", eoc0, 1'b0); chk("rst_ch0", ch0, 5'h0);      chk("rst_ovl0", ovl0, 1'b0);
      chk("rst_do1", do1, 16'h0);  chk("rst_busy1", busy1, 1'b0);
      rst = 1'b0;

      txn(0, 0, 7'h40, 16'h0, 0, 5'h0, 16'h0);
      txn(0, 0, 7'h10, 16'h0, 0, 5'h0, 16'h0);
      smp(5'h1C, 16'hABC0);
      txn(0, 0, 7'h1C, 16'h0, 0, 5'h0, 16'h0);
      txn(0, 1, 7'h41, 16'h1234, 0, 5'h0, 16'h0);
      txn(0, 0, 7'h41, 16'h0, 0, 5'h0, 16'h0);
      txn(0, 1, 7'h10, 16'hFFFF, 0, 5'h0, 16'h0);
      txn(0, 0, 7'h10, 16'h0, 0, 5'h0, 16'h0);
      smp(5'h10, 16'h1110);
      txn(0, 0, 7'h10, 16'h0, 1, 5'h10, 16'h5550);
      txn(0, 0, 7'h10, 16'h0, 0, 5'h0, 16'h0);
      txn(1, 0, 7'h45, 16'h0, 0, 5'h0, 16'h0);
      txn(1, 1, 7'h45, 16'hBEEF, 0, 5'h0, 16'h0);
      txn(1, 0, 7'h45, 16'h0, 0, 5'h0, 16'h0);

      // back-to-back samples give one eoc each
      @(posedge clk); #1;
      smp_valid = 1'b1; smp_ch = 5'h03; smp_data = 16'h3330; stat_m[3] = 16'h3330;
      @(posedge clk); #1;
      smp_ch = 5'h04; smp_data = 16'h4440; stat_m[4] = 16'h4440;
      chk("b2b_eoc1", eoc0, 1'b1); chk("b2b_ch1", ch0, 5'h03);
      @(posedge clk); #1;
      smp_valid = 1'b0;
      chk("b2b_eoc2", eoc0, 1'b1); chk("b2b_ch2", ch0, 5'h04);
      @(posedge clk); #1;
      chk("b2b_eoc3", eoc0, 1'b0);

      chk("ovl_clear", ovl0, 1'b0);
      // den at T and again at T+2 on the latency-4 instance
      @(posedge clk); #1;
      sel = 1'b0; den0 = 1'b1; dwe = 1'b0; daddr = 7'h41;
      exp = model_read(0, 7'h41);
      @(posedge clk); #1; den0 = 1'b0;
      @(posedge clk); #1; den0 = 1'b1; daddr = 7'h40;
      @(posedge clk); #1; den0 = 1'b0;
      ndr = 0; first = 0;
      for (int j = 4; j <= 12; j++) begin
         @(posedge clk); #1;
         if (drdy0) begin
            ndr++;
            if (first == 0) begin
               first = j;
               chk("ovl_do", do0, exp);
            end
         end
      end
      chk("ovl_drdy_count", ndr, 1);
      chk("ovl_drdy_cycle", first, 4);
      chk("ovl_set", ovl0, 1'b1);

      for (int it = 0; it < 80; it++) begin
         int r;
         logic [6:0] a;
         r = $urandom_range(0, 9);
         a = 7'($urandom);
         if ($urandom_range(0, 1) == 1) a[6] = 1'b1;
         if (r < 2) smp(5'($urandom), 16'($urandom));
         else txn(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0), a, 16'($urandom),
                  ($urandom_range(0, 3) == 0), 5'($urandom), 16'($urandom));
      end
      chk("ovl_sticky", ovl0, 1'b1);
      chk("ovl_lat1_clear", ovl1, 1'b0);

      // reset two cycles into a read drops it completely
      @(posedge clk); #1;
      sel = 1'b0; den0 = 1'b1; dwe = 1'b0; daddr = 7'h40;
      @(posedge clk); #1; den0 = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      chk("mrst_do", do0, 16'h0);  chk("mrst_drdy", drdy0, 1'b0); chk("mrst_busy", busy0, 1'b0);
      chk("mrst_eoc", eoc0, 1'b0); chk("mrst_ch", ch0, 5'h0);      chk("mrst_ovl", ovl0, 1'b0);
      rst = 1'b0;
      model_reset();
      ndr = 0;
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         if (drdy0) ndr++;
      end
      chk("mrst_no_drdy", ndr, 0);
      txn(0, 0, 7'h41, 16'h0, 0, 5'h0, 16'h0);
      txn(0, 0, 7'h1C, 16'h0, 0, 5'h0, 16'h0);
      txn(1, 0, 7'h45, 16'h0, 0, 5'h0, 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
